lane_deskew_fifo_rx: RTL and testbench

LANE_DESKEW_FIFO_RX -- requirements
Module: lane_deskew_fifo_rx

---
 rtl/lane_deskew_fifo_rx.sv | 133 +++++++++++++
 tb/tb_lane_deskew_fifo_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_deskew_fifo_rx.sv
// Multi-lane receive deskew: one circular FIFO per lane, filled from each lane's first alignment
// marker and drained in lock-step so that blocks sharing a marker index come out together.
module lane_deskew_fifo_rx #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66,
    parameter int DEPTH   = 32,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANE_N-1:0]          valid_i,
    input  logic [LANE_N-1:0]          lock_i,
    input  logic [LANE_N-1:0]          am_v_i,
    input  logic [LANE_N*BLOCK_W-1:0]  data_i,
    output logic                       valid_o,
    output logic                       am_v_o,
    output logic [LANE_N*BLOCK_W-1:0]  data_o,
    output logic                       aligned_o,
    output logic                       skew_err_o,
    output logic [LANE_N*CNT_W-1:0]    skew_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEARCH, ALIGNED} state_t;
    state_t state, state_nxt;

    logic [BLOCK_W:0]          mem     [LANE_N][DEPTH];
    logic [PTR_W-1:0]          wr_ptr  [LANE_N];
    logic [PTR_W-1:0]          rd_ptr  [LANE_N];
    logic [CNT_W-1:0]          occ     [LANE_N];
    logic [CNT_W-1:0]          occ_nxt [LANE_N];
    logic [CNT_W-1:0]          min_occ;
    logic [LANE_N-1:0]         found, found_nxt, wr_req, wr_en, full_hit, empty, head_am;
    logic [LANE_N*BLOCK_W-1:0] head_data;
    logic                      rd_en, mixed, err, flush;

    assign rd_en     = (state == ALIGNED) && (empty == '0);
    assign mixed     = !((&head_am) || (head_am == '0));
    assign err       = (|full_hit) || (rd_en && mixed);
    assign flush     = (state_nxt == IDLE);
    assign aligned_o = (state == ALIGNED);

    // A full lane may still accept a block in a cycle where the set is popped.
    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        assign empty[l]     = (occ[l] == '0);
        assign wr_req[l]    = valid_i[l] && ((state == ALIGNED) ||
                              ((state == SEARCH) && (found[l] || am_v_i[l])));
        assign full_hit[l]  = wr_req[l] && (occ[l] == CNT_W'(DEPTH)) && !rd_en;
        assign wr_en[l]     = wr_req[l] && !full_hit[l];
        assign found_nxt[l] = found[l] || wr_en[l];
        assign {head_am[l], head_data[l*BLOCK_W +: BLOCK_W]} = mem[l][rd_ptr[l]];
    end

    always_comb begin
        for (int l = 0; l < LANE_N; l++) begin
            occ_nxt[l] = occ[l] + CNT_W'(wr_en[l]) - CNT_W'(rd_en);
        end
        min_occ = occ_nxt[0];
        for (int l = 1; l < LANE_N; l++) begin
            if (occ_nxt[l] < min_occ) min_occ = occ_nxt[l];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (&lock_i) state_nxt = SEARCH;
            SEARCH:  if (!(&lock_i) || err) state_nxt = IDLE;
                     else if (&found_nxt) state_nxt = ALIGNED;
            ALIGNED: if (!(&lock_i) || err) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANE_N; l++) begin
            if (wr_en[l]) mem[l][wr_ptr[l]] <= {am_v_i[l], data_i[l*BLOCK_W +: BLOCK_W]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            found <= '0;
            for (int l = 0; l < LANE_N; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                occ[l]    <= '0;
            end
        end else if (flush) begin
            found <= '0;
            for (int l = 0; l < LANE_N; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                occ[l]    <= '0;
            end
        end else begin
            found <= (state == SEARCH) ? found_nxt : '0;
            for (int l = 0; l < LANE_N; l++) begin
                if (wr_en[l]) wr_ptr[l] <= wr_ptr[l] + PTR_W'(1);
                if (rd_en)    rd_ptr[l] <= rd_ptr[l] + PTR_W'(1);
                occ[l] <= occ_nxt[l];
            end
        end
    end

    // A popped set with mixed marker flags is a deskew failure, so it is never presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o    <= 1'b0;
            am_v_o     <= 1'b0;
            data_o     <= '0;
            skew_err_o <= 1'b0;
            skew_o     <= '0;
        end else begin
            valid_o    <= rd_en && !mixed;
            am_v_o     <= rd_en && (&head_am);
            skew_err_o <= err;
            if (rd_en) data_o <= head_data;
            if ((state == SEARCH) && (state_nxt == ALIGNED)) begin
                for (int l = 0; l < LANE_N; l++) begin
                    skew_o[l*CNT_W +: CNT_W] <= occ_nxt[l] - min_occ;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_deskew_fifo_rx.sv
// Bench for lane_deskew_fifo_rx: randomized per-lane block streams with periodic alignment markers,
// checked against a queue-based reference model through an expected-set scoreboard.
module tb_lane_deskew_fifo_rx;

    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int DEPTH   = 32;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int DW      = LANE_N * BLOCK_W;
    localparam int AM_PER  = 16;

    typedef logic [DW:0] word_t;
    typedef enum int {M_IDLE, M_SEARCH, M_ALIGNED} mode_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [LANE_N-1:0]       valid_i, lock_i, am_v_i;
    logic [DW-1:0]           data_i;
    logic                    valid_o, am_v_o, aligned_o, skew_err_o;
    logic [DW-1:0]           data_o;
    logic [LANE_N*CNT_W-1:0] skew_o;

    lane_deskew_fifo_rx #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .lock_i(lock_i), .am_v_i(am_v_i),
        .data_i(data_i), .valid_o(valid_o), .am_v_o(am_v_o), .data_o(data_o),
        .aligned_o(aligned_o), .skew_err_o(skew_err_o), .skew_o(skew_o)
    );

    // ---------------- clock / counters ----------------
    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;
    int n_err   = 0;
    int cyc     = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    mode_t                   m_mode  = M_IDLE;
    logic [BLOCK_W:0]        lq[LANE_N][$];
    logic [LANE_N-1:0]       m_found = '0;
    logic                    m_err   = 1'b0;
    logic [LANE_N*CNT_W-1:0] m_skew  = '0;
    word_t                   exp_q[$];
    int                      exp_t_q[$];

    task automatic model_step();
        bit lock_all, rd, err, all_am, any_am;
        bit want [LANE_N];
        int mn;
        logic [BLOCK_W:0] e;
        logic [DW-1:0] set_d;
        lock_all = &lock_i;
        err = 0; all_am = 1; any_am = 0; set_d = '0;
        if (m_mode == M_IDLE) begin
            m_err = 1'b0;
            m_found = '0;
            if (lock_all) m_mode = M_SEARCH;
            return;
        end
        rd = (m_mode == M_ALIGNED);
        for (int l = 0; l < LANE_N; l++) if (lq[l].size() == 0) rd = 0;
        for (int l = 0; l < LANE_N; l++) begin
            want[l] = valid_i[l] && (m_mode == M_ALIGNED || m_found[l] || am_v_i[l]);
            if (want[l] && lq[l].size() == DEPTH && !rd) begin
                err = 1;
                want[l] = 0;
            end
        end
        if (rd) begin
            for (int l = 0; l < LANE_N; l++) begin
                e = lq[l].pop_front();
                set_d[l*BLOCK_W +: BLOCK_W] = e[BLOCK_W-1:0];
                all_am &= e[BLOCK_W];
                any_am |= e[BLOCK_W];
            end
            if (all_am || !any_am) begin
                exp_q.push_back({all_am, set_d});
                exp_t_q.push_back(cyc);
            end else begin
                err = 1;
            end
        end
        for (int l = 0; l < LANE_N; l++) begin
            if (want[l]) begin
                lq[l].push_back({am_v_i[l], data_i[l*BLOCK_W +: BLOCK_W]});
                if (am_v_i[l]) m_found[l] = 1'b1;
            end
        end
        m_err = err;
        if (!lock_all || err) begin
            m_mode = M_IDLE;
            for (int l = 0; l < LANE_N; l++) lq[l].delete();
        end else if (m_mode == M_SEARCH && (&m_found)) begin
            mn = lq[0].size();
            for (int l = 1; l < LANE_N; l++) if (lq[l].size() < mn) mn = lq[l].size();
            for (int l = 0; l < LANE_N; l++) m_skew[l*CNT_W +: CNT_W] = CNT_W'(lq[l].size() - mn);
            m_mode = M_ALIGNED;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_mode = M_IDLE;
            m_found = '0;
            m_err = 1'b0;
            m_skew = '0;
            for (int l = 0; l < LANE_N; l++) lq[l].delete();
            exp_q.delete();
            exp_t_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        word_t e;
        int    t;
        @(negedge clk);
        if (!reset) begin
            check("aligned_o", word_t'(aligned_o), word_t'(m_mode == M_ALIGNED));
            check("skew_err_o", word_t'(skew_err_o), word_t'(m_err));
            check("skew_o", word_t'(skew_o), word_t'(m_skew));
            if (skew_err_o) n_err++;
            if (valid_o) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_o: got set %0h while none expected", data_o);
                end else begin
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    check("out_set", {am_v_o, data_o}, e);
                    check("out_cycle", word_t'(cyc), word_t'(t));
                end
            end else begin
                check("am_v_o_without_valid", word_t'(am_v_o), '0);
            end
        end
    end

    // ---------------- driver ----------------
    int idx       [LANE_N];
    int start_cyc [LANE_N];
    int gap_pct   [LANE_N];
    int half_lane, inject_lane, inject_t, drop_lane, drop_t;
    bit no_am;

    task automatic drive_cycle(input int t);
        logic [95:0] r;
        bit v;
        @(posedge clk);
        #2;
        for (int l = 0; l < LANE_N; l++) begin
            lock_i[l] = !(l == drop_lane && t == drop_t);
            r = {$urandom, $urandom, $urandom};
            data_i[l*BLOCK_W +: BLOCK_W] = r[BLOCK_W-1:0];
            if (t < start_cyc[l]) begin
                valid_i[l] = 1'b1;
                am_v_i[l]  = 1'b0;
            end else begin
                v = (half_lane == l) ? (t % 2 == 0) : ($urandom_range(99) < gap_pct[l]);
                valid_i[l] = v;
                am_v_i[l]  = v ? (((idx[l] % AM_PER == 0) && !no_am) || (l == inject_lane && t == inject_t))
                               : 1'($urandom_range(1));
                if (v) idx[l]++;
            end
        end
    endtask

    task automatic new_stream();
        @(posedge clk);
        #2;
        lock_i = '0; valid_i = '0; am_v_i = '0;
        repeat (3) @(posedge clk);
        for (int l = 0; l < LANE_N; l++) begin
            idx[l] = 0; start_cyc[l] = 0; gap_pct[l] = 100;
        end
        half_lane = -1; inject_lane = -1; inject_t = -1; drop_lane = -1; drop_t = -1; no_am = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int v0, e0;
        reset = 1'b1; valid_i = '0; lock_i = '0; am_v_i = '0; data_i = '0;
        for (int l = 0; l < LANE_N; l++) begin
            idx[l] = 0; start_cyc[l] = 0; gap_pct[l] = 100;
        end
        half_lane = -1; inject_lane = -1; inject_t = -1; drop_lane = -1; drop_t = -1; no_am = 0;
        v0 = 0; e0 = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid_o", word_t'(valid_o), '0);
        check("rst_am_v_o", word_t'(am_v_o), '0);
        check("rst_aligned_o", word_t'(aligned_o), '0);
        check("rst_skew_err_o", word_t'(skew_err_o), '0);
        check("rst_data_o", word_t'(data_o), '0);
        check("rst_skew_o", word_t'(skew_o), '0);
        reset = 1'b0;

        // Marker skew 10/12/11/15, then lock drop, stray marker and a half-rate lane
        start_cyc[0] = 10; start_cyc[1] = 12; start_cyc[2] = 11; start_cyc[3] = 15;
        drop_lane = 2; drop_t = 40; inject_lane = 1; inject_t = 55;
        for (int t = 0; t < 115; t++) begin
            if (t == 85) half_lane = 2;
            if (t == 105) half_lane = -1;
            drive_cycle(t);
            if (t == 15) check("aligned_before_last_am", word_t'(aligned_o), '0);
            if (t == 16) check("aligned_at_16", word_t'(aligned_o), word_t'(1));
            if (t == 16) check("no_valid_at_16", word_t'(valid_o), '0);
            if (t == 17) check("first_am_set_at_17", word_t'({valid_o, am_v_o}), word_t'(3));
            if (t == 20) check("skew_capture", word_t'(skew_o), word_t'({6'd0, 6'd4, 6'd3, 6'd5}));
            if (t == 41) check("lock_drop_unaligned", word_t'(aligned_o), '0);
            if (t == 50) check("realign_after_lock", word_t'(aligned_o), word_t'(1));
            if (t == 54) e0 = n_err;
            if (t == 75) check("stray_am_one_error", word_t'(n_err - e0), word_t'(1));
            if (t == 85) begin v0 = n_valid; e0 = n_err; end
            if (t == 105) begin
                check("half_rate_no_error", word_t'(n_err - e0), '0);
                check("half_rate_count", word_t'((n_valid - v0) >= 8 && (n_valid - v0) <= 12), word_t'(1));
            end
        end

        // Lane 3 marker DEPTH cycles after lane 0 overflows lane 0
        new_stream();
        start_cyc[0] = 10; start_cyc[1] = 10; start_cyc[2] = 10; start_cyc[3] = 10 + DEPTH;
        e0 = n_err;
        for (int t = 0; t < 50; t++) drive_cycle(t);
        check("overflow_one_pulse", word_t'(n_err - e0), word_t'(1));
        check("overflow_unaligned", word_t'(aligned_o), '0);

        // Reset while aligned with a deep FIFO, then no valid_o until markers return
        new_stream();
        start_cyc[0] = 2; start_cyc[1] = 10; start_cyc[2] = 6; start_cyc[3] = 18;
        for (int t = 0; t < 30; t++) drive_cycle(t);
        check("aligned_before_reset", word_t'(aligned_o), word_t'(1));
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid_o", word_t'(valid_o), '0);
        check("midrst_am_v_o", word_t'(am_v_o), '0);
        check("midrst_aligned_o", word_t'(aligned_o), '0);
        check("midrst_skew_err_o", word_t'(skew_err_o), '0);
        check("midrst_data_o", word_t'(data_o), '0);
        check("midrst_skew_o", word_t'(skew_o), '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        no_am = 1;
        v0 = n_valid;
        for (int t = 30; t < 50; t++) drive_cycle(t);
        check("no_valid_after_reset", word_t'(n_valid - v0), '0);
        no_am = 0;
        for (int t = 50; t < 90; t++) drive_cycle(t);

        // Randomized skew, gaps and lock drops
        for (int round = 0; round < 4; round++) begin
            new_stream();
            for (int l = 0; l < LANE_N; l++) begin
                start_cyc[l] = $urandom_range(20);
                gap_pct[l]   = ($urandom_range(1) == 1) ? 95 : 100;
            end
            drop_lane = ($urandom_range(1) == 1) ? int'($urandom_range(LANE_N - 1)) : -1;
            drop_t    = $urandom_range(140, 60);
            for (int t = 0; t < 150; t++) drive_cycle(t);
        end

        new_stream();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", word_t'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
